// File: rtl/alu_txn_responder.sv
// ALU transaction responder: valid/ready request side, two-stage ALU pipeline,
// credit-gated result FIFO on the response side, and a delivered-response counter.
module alu_txn_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      txn_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
    OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
    OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // Stage 1: captured request
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: computed result
  logic             s2_valid;
  rsp_t             s2_entry;

  // Result FIFO
  rsp_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_count;
  logic             wr_en;
  logic             rd_en;
  logic             req_fire;
  logic [AW+1:0]    occupancy;

  // Every accepted request owns a FIFO slot from acceptance onward, so the
  // FIFO can never overflow and the pipeline never has to stall.
  assign occupancy = (AW+2)'(fifo_count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
  assign req_ready = occupancy < (AW+2)'(DEPTH);
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid = (fifo_count != '0);
  assign wr_en     = s2_valid;
  assign rd_en     = rsp_valid && rsp_ready;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= req_fire;
      s2_valid <= s1_valid;
    end
  end

  // Datapath registers carry no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_a   <= A;
      s1_b   <= B;
      s1_op  <= alu_op_e'(ALU_Sel);
      s1_tag <= req_tag;
    end
  end

  logic [WIDTH:0]     sum_full;
  logic [WIDTH:0]     diff_full;
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  assign sum_full  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_full = {1'b0, s1_a} - {1'b0, s1_b};
  assign prod_full = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (s1_op)
      OP_ADD:  begin alu_res = sum_full[WIDTH-1:0];  alu_carry = sum_full[WIDTH];  end
      OP_SUB:  begin alu_res = diff_full[WIDTH-1:0]; alu_carry = diff_full[WIDTH]; end
      OP_MUL:  alu_res = prod_full[WIDTH-1:0];
      OP_DIV:  alu_res = (s1_b == '0) ? '1 : (s1_a / s1_b);
      OP_SHL:  alu_res = {s1_a[WIDTH-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, s1_a[WIDTH-1:1]};
      OP_ROL:  alu_res = {s1_a[WIDTH-2:0], s1_a[WIDTH-1]};
      OP_ROR:  alu_res = {s1_a[0], s1_a[WIDTH-1:1]};
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_NOR:  alu_res = ~(s1_a | s1_b);
      OP_NAND: alu_res = ~(s1_a & s1_b);
      OP_XNOR: alu_res = ~(s1_a ^ s1_b);
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (s1_a > s1_b)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_entry.res   <= alu_res;
      s2_entry.carry <= alu_carry;
      s2_entry.tag   <= s1_tag;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; emptiness is tracked by the
  // pointers/count, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s2_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      txn_count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr    <= rd_ptr + AW'(1);
        txn_count <= txn_count + 16'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  rsp_t head;
  assign head     = mem[rd_ptr];
  assign ALU_Out  = rsp_valid ? head.res   : '0;
  assign CarryOut = rsp_valid ? head.carry : 1'b0;
  assign rsp_tag  = rsp_valid ? head.tag   : '0;

endmodule

// File: tb/tb_alu_txn_responder.sv
// Self-checking bench for alu_txn_responder: a queue-based transaction model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_txn_responder;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int MASK  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALU_Sel;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  ALU_Out;
  logic          CarryOut;
  logic [TW-1:0] rsp_tag;
  logic [15:0]   txn_count;

  alu_txn_responder #(.WIDTH(W), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .rsp_tag(rsp_tag),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Op table evaluated with plain integer arithmetic.
  function automatic void ref_alu(input int a, input int b, input int sel,
                                  output int res, output int c);
    c = 0;
    case (sel)
      0:  begin res = (a + b) & MASK; c = ((a + b) > MASK) ? 1 : 0; end
      1:  begin res = (a - b) & MASK; c = (a < b) ? 1 : 0; end
      2:  res = (a * b) & MASK;
      3:  res = (b == 0) ? MASK : a / b;
      4:  res = (a * 2) & MASK;
      5:  res = a / 2;
      6:  res = ((a * 2) & MASK) | (a / (1 << (W - 1)));
      7:  res = (a / 2) | ((a % 2) << (W - 1));
      8:  res = a & b;
      9:  res = a | b;
      10: res = a ^ b;
      11: res = ~(a | b) & MASK;
      12: res = ~(a & b) & MASK;
      13: res = ~(a ^ b) & MASK;
      14: res = (a > b) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
  endfunction

  // Transaction model: each accepted request is visible at the head two edges
  // after acceptance; outstanding requests (accepted, not yet delivered) cap at DEPTH.
  typedef struct {
    int res;
    int c;
    int tag;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   delivered = 0;
  bit   cmp_en    = 1'b0;
  int   m_out;
  bit   m_vis;
  exp_t m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      delivered = 0;
    end else begin
      m_out = q.size();
      m_vis = (q.size() > 0) && (cyc >= q[0].stamp + 2);
      if (m_vis && rsp_ready) begin
        void'(q.pop_front());
        delivered++;
      end
      if (req_valid && (m_out < DEPTH)) begin
        ref_alu(int'(A), int'(B), int'(ALU_Sel), m_e.res, m_e.c);
        m_e.tag   = int'(req_tag);
        m_e.stamp = cyc + 1;
        q.push_back(m_e);
      end
    end
    cyc++;
  end

  bit c_vis;
  always @(negedge clk) begin
    if (cmp_en) begin
      c_vis = (q.size() > 0) && (cyc >= q[0].stamp + 2);
      check("m_req_ready", req_ready, (q.size() < DEPTH));
      check("m_rsp_valid", rsp_valid, c_vis);
      check("m_txn_count", txn_count, delivered & 16'hFFFF);
      if (c_vis) begin
        check("m_alu_out", ALU_Out, q[0].res);
        check("m_carry",   CarryOut, q[0].c);
        check("m_tag",     rsp_tag, q[0].tag);
      end
    end
  end

  task automatic randomize_req();
    A       = W'($urandom);
    B       = W'($urandom);
    ALU_Sel = 4'($urandom);
    req_tag = TW'($urandom);
  endtask

  task automatic send_one(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [3:0] tag,
                          input logic [7:0] eo, input logic ec);
    @(posedge clk); #1;
    A = a; B = b; ALU_Sel = sel; req_tag = tag; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({nm, "_v_n0"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    check({nm, "_v_n1"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    check({nm, "_v_n2"}, rsp_valid, 1'b1);
    check({nm, "_out"},  ALU_Out, eo);
    check({nm, "_c"},    CarryOut, ec);
    check({nm, "_tag"},  rsp_tag, tag);
    @(posedge clk); #1;
  endtask

  int  n;
  int  guard;
  bit  acc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    A = '0; B = '0; ALU_Sel = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_out",   ALU_Out, 8'h00);
    check("rst_carry",     CarryOut, 1'b0);
    check("rst_tag",       rsp_tag, 4'h0);
    check("rst_txn_count", txn_count, 16'h0000);
    check("rst_req_ready", req_ready, 1'b1);

    send_one("xor",  8'hF0, 8'h3C, 4'b1010, 4'd5, 8'hCC, 1'b0);
    send_one("add",  8'hFF, 8'h01, 4'b0000, 4'd1, 8'h00, 1'b1);
    send_one("sub",  8'h10, 8'h20, 4'b0001, 4'd2, 8'hF0, 1'b1);
    send_one("div0", 8'h07, 8'h00, 4'b0011, 4'd3, 8'hFF, 1'b0);
    send_one("rotl", 8'h81, 8'h55, 4'b0110, 4'd4, 8'h03, 1'b0);
    repeat (2) @(posedge clk);

    // Backpressure: only DEPTH requests can be outstanding.
    #1;
    rsp_ready = 1'b0; req_valid = 1'b1; randomize_req(); req_tag = 4'd8;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        randomize_req();
        req_tag = TW'(8 + n);
      end
    end
    check("bp_accepted", n, 4);
    check("bp_req_ready_low", req_ready, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_tag_order", rsp_tag, 8 + i);
      @(posedge clk); #1;
      if (i == 0) check("bp_ready_after_pop", req_ready, 1'b1);
    end

    // Random traffic with random backpressure, checked by the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      randomize_req();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    guard = 0;
    repeat (3) @(posedge clk);
    while (rsp_valid && guard < 20) begin @(posedge clk); guard++; end
    check("drain_timeout", (guard < 20), 1'b1);

    // Reset with three requests in flight.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; randomize_req();
    repeat (3) begin @(posedge clk); #1; randomize_req(); end
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_txn_count", txn_count, 16'h0000);
    check("mid_rst_req_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", rsp_valid, 1'b0);
    end

    // Streaming: 100 random ops with req_valid and rsp_ready held high.
    @(posedge clk); #1;
    req_valid = 1'b1; rsp_ready = 1'b1; randomize_req();
    n = 0; guard = 0;
    while (n < 100 && guard < 1000) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin n++; randomize_req(); end
    end
    req_valid = 1'b0;
    check("stream_accepted", n, 100);
    check("stream_cycles", guard, 100);
    guard = 0;
    @(negedge clk);
    while ((rsp_valid || q.size() > 0) && guard < 20) begin @(negedge clk); guard++; end
    check("stream_drain_timeout", (guard < 20), 1'b1);
    check("stream_txn_count", txn_count, 16'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_txn_responder.md
# alu_txn_responder

Synthesizable responder end of the ALU stimulus interface. It accepts ALU operation requests (A, B, ALU_Sel) over a valid/ready handshake, computes them in a two-stage pipeline, and returns results (ALU_Out, CarryOut, tag) over a second valid/ready handshake through a small result FIFO. It sits between a stimulus initiator and a result consumer (monitor/scoreboard), adding backpressure and ordering to the combinational ALU behaviour.

## Interface
- WIDTH, 8, operand and result width
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- TAG_W, 4, request tag width
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALU_Sel  in  4  operation select
- req_tag  in  TAG_W  opaque tag, echoed with result
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- ALU_Out  out  WIDTH  result
- CarryOut  out  1  carry/borrow flag
- rsp_tag  out  TAG_W  echoed tag
- txn_count  out  16  responses delivered, wraps at 2^16

## Operation
- Request accepted on a rising edge with req_valid && req_ready; response delivered with rsp_valid && rsp_ready.
- Op table (result truncated to WIDTH):
  - 0000 A+B, CarryOut = bit WIDTH of full sum
  - 0001 A−B, CarryOut = 1 when A<B (borrow)
  - 0010 A*B low bits
  - 0011 A/B; B=0 → all ones
  - 0100 A<<1
  - 0101 A>>1
  - 0110 rotate A left 1
  - 0111 rotate A right 1
  - 1000 AND, 1001 OR, 1010 XOR, 1011 NOR, 1100 NAND, 1101 XNOR
  - 1110 (A>B) ? 1 : 0
  - 1111 (A==B) ? 1 : 0
  - CarryOut = 0 for every op except 0000 and 0001.
- Pipeline: stage 1 registers operands/sel/tag; stage 2 registers the computed result; stage 2 output writes the FIFO.
- Credit rule: req_ready = (fifo_count + inflight) < DEPTH, where inflight = number of valid pipeline stages (0–2). The pipeline never stalls; overflow is impossible by construction.
- FIFO is first-in first-out; responses leave in request order.
- rsp_valid = FIFO not empty; ALU_Out/CarryOut/rsp_tag present the head entry and stay stable while rsp_valid && !rsp_ready.
- txn_count increments by 1 per delivered response and wraps 0xFFFF→0x0000.

## Timing
- Reset (rst_n low at a rising edge): pipeline valids cleared, FIFO emptied, txn_count=0. Outputs: rsp_valid=0, ALU_Out=0, CarryOut=0, rsp_tag=0, req_ready=1 from the first edge after rst_n deasserts. Reset mid-operation discards all in-flight and buffered transactions.
- Latency: request accepted at edge N → rsp_valid=1 after edge N+2 (when the FIFO was empty and rsp_ready=1). Minimum 2 cycles, no bypass.
- Throughput: 1 transaction/cycle sustained when rsp_ready is held high.
- Simultaneous FIFO write and read in one cycle is legal at any occupancy, including full and empty-with-write; count is unchanged.
- req_ready is combinational from registered state only; it does not depend on req_valid or rsp_ready in the same cycle.
- Pointer wrap at DEPTH is seamless; no bubble.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release → rsp_valid=0, ALU_Out=0, txn_count=0, req_ready=1.
- Latency/XOR: A=0xF0, B=0x3C, Sel=1010, tag=5 at edge N with rsp_ready=1 → at N+2 rsp_valid=1, ALU_Out=0xCC, CarryOut=0, rsp_tag=5.
- Arithmetic corners: 0xFF+0x01 → 0x00, C=1; 0x10−0x20 → 0xF0, C=1; 0x07/0x00 → 0xFF; 0x81 rotl → 0x03.
- Backpressure: rsp_ready=0, issue back-to-back requests → exactly 4 accepted, then req_ready=0; set rsp_ready=1 → 4 responses in tag order, req_ready reasserts the cycle after the first pop.
- Streaming: 100 random ops with rsp_ready high and req_valid held → one response per cycle after 2-cycle fill, results match the op table, txn_count=100.
- Reset mid-flight: 3 requests in flight, pull rst_n low for one edge → FIFO empty, rsp_valid=0, no stale responses afterwards.
